// File: rtl/period_lock_ctrl_pkg.sv
// Shared types and defaults for the period lock controller.
package period_lock_ctrl_pkg;

  localparam int unsigned DEF_DW         = 8;
  localparam int unsigned DEF_MAX_LAG    = 8;
  localparam int unsigned DEF_LOCK_CNT   = 4;
  localparam int unsigned DEF_UNLOCK_CNT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_CONFIRM,
    ST_LOCKED
  } lock_state_t;

  // Width needed to hold lag values 0..max_lag.
  function automatic int unsigned lag_width(input int unsigned max_lag);
    return $clog2(max_lag + 1);
  endfunction

endpackage

// File: rtl/period_lock_ctrl_lag_cmp_line.sv
// Sample history line with fill tracking and a compare against the sample `lag` back.
module lag_cmp_line
  import period_lock_ctrl_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MAX_LAG = DEF_MAX_LAG,
  parameter int unsigned LW      = lag_width(DEF_MAX_LAG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          fill_clr,
  input  logic [LW-1:0] lag,
  input  logic [DW-1:0] data_in,
  output logic          cmp,
  output logic          cmp_valid
);

  logic [DW-1:0] hist [MAX_LAG];
  logic [LW-1:0] fill;
  logic [DW-1:0] tap;

  // Decoded mux avoids an index wider than the history depth.
  always_comb begin
    tap = '0;
    for (int unsigned k = 0; k < MAX_LAG; k++) begin
      if (lag == LW'(k + 1)) tap = hist[k];
    end
  end

  assign cmp_valid = shift & (fill >= lag);
  assign cmp       = (data_in == tap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MAX_LAG; k++) hist[k] <= '0;
    end else if (shift) begin
      hist[0] <= data_in;
      for (int unsigned k = 1; k < MAX_LAG; k++) hist[k] <= hist[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (fill_clr) begin
      fill <= '0;
    end else if (shift && (fill < LW'(MAX_LAG))) begin
      fill <= fill + LW'(1);
    end
  end

endmodule

// File: rtl/period_lock_ctrl.sv
// Hunt/confirm/lock controller that finds the repetition period of a sample stream.
module period_lock_ctrl
  import period_lock_ctrl_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MAX_LAG    = DEF_MAX_LAG,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
  parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT,
  localparam int unsigned LW        = lag_width(MAX_LAG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          data_vld,
  input  logic [DW-1:0] data_in,
  output logic [LW-1:0] lag,
  output logic          match,
  output logic          hunting,
  output logic          locked,
  output logic          sweep_fail
);

  localparam int unsigned HW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(UNLOCK_CNT + 1);

  lock_state_t   state;
  logic [HW-1:0] hit_cnt;
  logic [MW-1:0] miss_cnt;
  logic          cmp;
  logic          cmp_valid;
  logic          lag_wrap;
  logic [LW-1:0] lag_next;

  lag_cmp_line #(
    .DW      (DW),
    .MAX_LAG (MAX_LAG),
    .LW      (LW)
  ) u_line (
    .clk       (clk),
    .rst       (rst),
    .shift     (en & data_vld),
    .fill_clr  (state == ST_IDLE),
    .lag       (lag),
    .data_in   (data_in),
    .cmp       (cmp),
    .cmp_valid (cmp_valid)
  );

  assign lag_wrap = (lag == LW'(MAX_LAG));
  assign lag_next = lag_wrap ? LW'(1) : lag + LW'(1);

  assign hunting = (state == ST_HUNT) || (state == ST_CONFIRM);
  assign locked  = (state == ST_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      lag        <= LW'(1);
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      match      <= 1'b0;
      sweep_fail <= 1'b0;
    end else begin
      sweep_fail <= 1'b0;
      match      <= cmp_valid & cmp;
      if (!en) begin
        state    <= ST_IDLE;
        lag      <= LW'(1);
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_HUNT;
            lag      <= LW'(1);
            hit_cnt  <= '0;
            miss_cnt <= '0;
          end
          ST_HUNT: begin
            if (cmp_valid) begin
              if (cmp) begin
                if (LOCK_CNT == 1) begin
                  state <= ST_LOCKED;
                end else begin
                  state   <= ST_CONFIRM;
                  hit_cnt <= HW'(1);
                end
              end else begin
                lag        <= lag_next;
                sweep_fail <= lag_wrap;
              end
            end
          end
          ST_CONFIRM: begin
            if (cmp_valid) begin
              if (cmp) begin
                if (hit_cnt == HW'(LOCK_CNT - 1)) begin
                  state   <= ST_LOCKED;
                  hit_cnt <= '0;
                end else begin
                  hit_cnt <= hit_cnt + HW'(1);
                end
              end else begin
                state      <= ST_HUNT;
                lag        <= lag_next;
                sweep_fail <= lag_wrap;
                hit_cnt    <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (cmp_valid) begin
              if (cmp) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MW'(UNLOCK_CNT - 1)) begin
                state    <= ST_HUNT;
                hit_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + MW'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_lock_ctrl.sv
// Randomized scoreboard bench for period_lock_ctrl against a behavioural period-search model.
module tb_period_lock_ctrl;
  import period_lock_ctrl_pkg::*;

  localparam int unsigned DW         = 8;
  localparam int unsigned MAX_LAG    = 8;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned UNLOCK_CNT = 2;
  localparam int unsigned LW         = lag_width(MAX_LAG);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          data_vld = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [LW-1:0] lag;
  logic          match, hunting, locked, sweep_fail;

  period_lock_ctrl #(
    .DW         (DW),
    .MAX_LAG    (MAX_LAG),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_vld   (data_vld),
    .data_in    (data_in),
    .lag        (lag),
    .match      (match),
    .hunting    (hunting),
    .locked     (locked),
    .sweep_fail (sweep_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int h;
    int l;
    int lg;
    int sf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sweep_seen = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: search over candidate periods using the last seen samples.
  // mode: 0 idle, 1 searching (no run yet), 2 building a run of matches, 3 locked
  int m_mode, m_lag, m_run, m_misses, m_seen;
  int m_past[$];

  function automatic void model_reset();
    m_mode = 0; m_lag = 1; m_run = 0; m_misses = 0; m_seen = 0;
    m_past.delete();
    for (int i = 0; i < int'(MAX_LAG); i++) m_past.push_back(0);
  endfunction

  function automatic int bump_lag(inout int sf);
    if (m_lag == int'(MAX_LAG)) begin
      sf = 1;
      return 1;
    end
    return m_lag + 1;
  endfunction

  function automatic exp_t model_step(input int e, input int v, input int d);
    exp_t r;
    int   was_idle, usable, hit, sf;
    sf = 0;
    was_idle = (m_mode == 0);
    usable = e && v && (m_seen >= m_lag);
    hit = usable && (d == m_past[m_lag-1]);
    if (!e) begin
      m_mode = 0; m_lag = 1; m_run = 0; m_misses = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_lag = 1; m_run = 0; m_misses = 0;
    end else if (usable) begin
      if (m_mode == 3) begin
        m_misses = hit ? 0 : m_misses + 1;
        if (m_misses == int'(UNLOCK_CNT)) begin
          m_mode = 1; m_run = 0; m_misses = 0;
        end
      end else if (hit) begin
        m_run++;
        m_mode = (m_run >= int'(LOCK_CNT)) ? 3 : 2;
        if (m_mode == 3) m_run = 0;
      end else begin
        m_mode = 1; m_run = 0;
        m_lag = bump_lag(sf);
      end
    end
    if (was_idle) m_seen = 0;
    else if (e && v && m_seen < int'(MAX_LAG)) m_seen++;
    if (e && v) begin
      m_past.push_front(d);
      void'(m_past.pop_back());
    end
    r.m = hit; r.h = (m_mode == 1 || m_mode == 2); r.l = (m_mode == 3);
    r.lg = m_lag; r.sf = sf;
    return r;
  endfunction

  // Monitor: compares every post-edge DUT output against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sweep_fail === 1'b1) sweep_seen++;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("match", int'(match), x.m);
        check("hunting", int'(hunting), x.h);
        check("locked", int'(locked), x.l);
        check("lag", int'(lag), x.lg);
        check("sweep_fail", int'(sweep_fail), x.sf);
      end
    end
  end

  task automatic step(input logic e, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    en = e; data_vld = v; data_in = d;
    sb.push_back(model_step(int'(e), int'(v), int'(d)));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic restart();
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  logic [DW-1:0] p4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int ph;

  task automatic p4_run(input int n, input int toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle != 0) step(1'b1, 1'b0, 8'hEE);
      step(1'b1, 1'b1, p4[ph % 4]);
      ph++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pat [8];
    int per, pidx, e, v;
    logic [DW-1:0] d;
    model_reset();
    #12;
    check("rst_lag", int'(lag), 1);
    check("rst_locked", int'(locked), 0);
    check("rst_hunting", int'(hunting), 0);
    check("rst_match", int'(match), 0);
    check("rst_sweep", int'(sweep_fail), 0);
    @(negedge clk); #1 rst = 1'b0;

    // Period-4 acquisition
    step(1'b1, 1'b0, '0);
    ph = 0;
    p4_run(8, 0);
    settle();
    check("p4_locked", int'(locked), 1);
    check("p4_lag", int'(lag), 4);
    check("p4_no_sweep", sweep_seen, 0);

    // Single corruption keeps lock; double corruption drops it
    p4_run(4, 0);
    step(1'b1, 1'b1, p4[ph % 4] ^ 8'hFF); ph++;
    settle();
    check("one_bad_match", int'(match), 0);
    check("one_bad_locked", int'(locked), 1);
    p4_run(8, 0);
    step(1'b1, 1'b1, p4[ph % 4] ^ 8'hFF); ph++;
    step(1'b1, 1'b1, p4[ph % 4] ^ 8'hFF); ph++;
    settle();
    check("two_bad_locked", int'(locked), 0);
    check("two_bad_hunting", int'(hunting), 1);
    check("two_bad_lag", int'(lag), 4);
    p4_run(24, 0);
    settle();
    check("relock_locked", int'(locked), 1);
    check("relock_lag48", int'(lag == 4 || lag == 8), 1);

    // Asynchronous reset between edges while locked
    @(posedge clk); #3;
    rst = 1'b1; en = 1'b0;
    #1;
    check("amid_locked", int'(locked), 0);
    check("amid_hunting", int'(hunting), 0);
    check("amid_match", int'(match), 0);
    check("amid_lag", int'(lag), 1);
    model_reset();
    @(negedge clk); #1 rst = 1'b0;
    step(1'b1, 1'b0, '0);
    ph = 0;
    p4_run(8, 0);
    settle();
    check("reacq_locked", int'(locked), 1);

    // Constant stream locks at lag 1 after five samples
    restart();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h5A);
    settle();
    check("const_locked", int'(locked), 1);
    check("const_lag", int'(lag), 1);

    // Incrementing stream never matches; sweep_fail once per MAX_LAG compares
    restart();
    sweep_seen = 0;
    for (int i = 0; i < 33; i++) step(1'b1, 1'b1, DW'(i));
    settle();
    check("inc_sweeps", sweep_seen, 4);
    check("inc_locked", int'(locked), 0);

    // Half-rate valid gives the same lock
    restart();
    ph = 0;
    p4_run(8, 1);
    settle();
    check("half_locked", int'(locked), 1);
    check("half_lag", int'(lag), 4);

    // One-cycle enable drop
    step(1'b0, 1'b1, p4[ph % 4]);
    settle();
    check("endrop_locked", int'(locked), 0);
    check("endrop_lag", int'(lag), 1);
    step(1'b1, 1'b0, '0);
    ph = 0;
    p4_run(8, 0);
    settle();
    check("endrop_relock", int'(locked), 1);

    // Randomized periods, gaps, corruptions and enable drops
    for (int i = 0; i < 1600; i++) begin
      if (i % 200 == 0) begin
        per = $urandom_range(1, MAX_LAG);
        for (int k = 0; k < 8; k++) pat[k] = DW'($urandom);
        pidx = 0;
      end
      e = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = pat[pidx % per];
      if ($urandom_range(0, 39) == 0) d = d ^ DW'($urandom_range(1, 255));
      if (e != 0 && v != 0) pidx++;
      step(logic'(e), logic'(v), d);
    end

    step(1'b0, 1'b0, '0);
    settle();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/period_lock_ctrl.md
Name: period_lock_ctrl

Overview:
- Controller that finds and tracks the repetition period of an incoming sample stream.
- Holds a sample history line and compares each new sample against the sample `lag` positions back.
- A hunt/confirm/lock state machine steps `lag` through 1..MAX_LAG until the stream repeats consistently.
- Sits upstream of any logic that needs a stable period (frame alignment, pattern-lock indication). Reports the selected lag, lock status and a per-sample match flag.

Parameters:
- DW, 8, sample width in bits
- MAX_LAG, 8, largest period searched (>=2); history depth
- LOCK_CNT, 4, consecutive matches needed to declare lock (>=1)
- UNLOCK_CNT, 2, consecutive misses in LOCKED that drop lock (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  enable; low forces IDLE
- data_vld  in  1  qualifies data_in this cycle
- data_in  in  DW  sample
- lag  out  LW=$clog2(MAX_LAG+1)  current compare distance
- match  out  1  registered compare result for the last valid sample
- hunting  out  1  high in HUNT or CONFIRM
- locked  out  1  high in LOCKED
- sweep_fail  out  1  one-cycle pulse when lag wraps MAX_LAG->1

Behaviour:
- Reset (async, rst=1): history all 0; fill=0; lag=1; match, hunting, locked, sweep_fail = 0; state IDLE; hit_cnt and miss_cnt = 0.
- History line: MAX_LAG x DW shift register.
  - Shifts on en & data_vld: hist[0] <= data_in, hist[k] <= hist[k-1].
  - fill counts valid samples since entering HUNT and saturates at MAX_LAG.
- Compare is valid when en & data_vld & (fill >= lag).
  - cmp = (data_in == hist[lag-1]), using pre-shift history.
  - match <= cmp when compare is valid, else 0. Latency is 1 cycle.
- All state, lag and counter updates happen only on valid compares. Cycles with data_vld=0, or with fill < lag, change nothing except sweep_fail, which returns to 0.
- FSM states and transitions:
  - IDLE: lag=1, counters cleared, fill held at 0. When en=1, go to HUNT next cycle.
  - HUNT: on match, go to CONFIRM with hit_cnt=1. If LOCK_CNT=1, go directly to LOCKED. On miss, advance lag; at MAX_LAG, lag wraps to 1 and sweep_fail pulses.
  - CONFIRM: on match, hit_cnt++. When hit_cnt reaches LOCK_CNT, go to LOCKED. On miss, go to HUNT, advance lag (same wrap rule), hit_cnt=0.
  - LOCKED: on match, miss_cnt=0. On miss, miss_cnt++. When miss_cnt reaches UNLOCK_CNT, go to HUNT with lag unchanged and counters cleared; fill is not cleared.
- en=0 in any state: IDLE next cycle; locked, hunting and match cleared; lag=1. Valid samples arriving with en=0 are ignored.
- Outputs are registered: locked and hunting decode the registered state.
- Lag arithmetic is unsigned LW bits. lag is never 0 and never > MAX_LAG.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, HUNT, CONFIRM, LOCKED)
  - the LW width function
  - default parameter constants
- One natural sub-module: lag_cmp_line.
  - Contains the history shift register, the fill counter and the compare for a selected lag.
  - Its outputs are cmp and cmp_valid.
  - The FSM stays in the top level.

Test Plan:
- Reset mid-lock: drive to LOCKED, assert rst asynchronously between edges -> all outputs 0 and lag=1 immediately. After release and en=1, re-acquisition starts from HUNT.
- Period-4 stream 0x11,0x22,0x33,0x44 repeating, data_vld=1, en=1:
  - samples 2, 3, 4 miss, so lag steps 1->2->3->4
  - sample 5 matches (CONFIRM)
  - after sample 8, locked=1 with lag=4
  - sweep_fail stays 0
- Constant 0x5A stream -> first compare at sample 2 matches; locked=1 with lag=1 after sample 5.
- Incrementing counter 0x00,0x01,... -> match never 1, locked stays 0. sweep_fail pulses once every MAX_LAG valid compares, with lag cycling 1..8.
- Locked on the period-4 stream:
  - one corrupted sample -> match=0 for that sample; locked stays 1
  - two consecutive corrupted samples -> locked=0 the cycle after the second miss, with hunting=1 and lag=4
  - clean stream afterwards -> relock with lag in {4, 8}
- Period-4 stream with data_vld toggling 1010... -> same lock result as continuous, after twice the cycles. Dropping en for 1 cycle while locked -> IDLE, lag=1, locked=0. Re-acquisition on the next en=1.
